// File: rtl/mem_stall_controller.sv
// mem_stall_controller
//   Sequences one MEM-stage 32-bit data access onto a 16-bit asynchronous SRAM
//   as two halfword phases of WAIT_CYCLES clocks each, holding the pipeline
//   (ready=0) until the access completes.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   wr_en, rd_en          store / load request from the MEM stage (store wins)
//   address, wdata        byte address and store data, latched on acceptance
//   rdata                 load data; holds the last completed read
//   ready                 combinational: no access pending, or access done
//   sram_addr             SRAM halfword address
//   sram_dq_out/_in/_oe   SRAM data bus (out, in, controller-drives enable)
//   sram_we_n             SRAM write enable, active-low
module mem_stall_controller #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state, state_d;
    logic [CW-1:0]      count, count_d;
    logic               is_write, is_write_d;
    logic [SRAM_AW-1:0] lo_addr, lo_addr_d;
    logic [31:0]        wdata_q, wdata_q_d;

    logic [SRAM_AW-1:0] sram_addr_d;
    logic [15:0]        dq_out_d;
    logic               oe_d;
    logic               we_n_d;

    logic [31:0]        offset_c;
    logic               request_c;
    logic               last_c;

    // Byte offset from the SRAM window base, wrapping modulo 2^32.
    assign offset_c  = address - BASE_ADDR;
    assign request_c = rd_en | wr_en;
    assign last_c    = (count == LAST);

    // Freeze is released while idle with nothing asked, and for the DONE cycle.
    assign ready = ((state == S_IDLE) && !request_c) || (state == S_DONE);

    // Next state, phase counter and latched transaction.
    always_comb begin
        state_d    = state;
        count_d    = count;
        is_write_d = is_write;
        lo_addr_d  = lo_addr;
        wdata_q_d  = wdata_q;
        case (state)
            S_IDLE: begin
                if (request_c) begin
                    state_d    = S_LO;
                    count_d    = '0;
                    is_write_d = wr_en;
                    lo_addr_d  = SRAM_AW'((offset_c >> 2) << 1);
                    wdata_q_d  = wdata;
                end
            end
            S_LO: begin
                if (last_c) begin
                    state_d = S_HI;
                    count_d = '0;
                end else begin
                    count_d = count + CW'(1);
                end
            end
            S_HI: begin
                if (last_c) begin
                    state_d = S_DONE;
                    count_d = '0;
                end else begin
                    count_d = count + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    // SRAM pin values for the coming cycle, derived from the next state so the
    // registered pins line up with the phase they belong to.
    always_comb begin
        sram_addr_d = sram_addr;
        dq_out_d    = sram_dq_out;
        oe_d        = 1'b0;
        we_n_d      = 1'b1;
        if (state_d == S_LO) begin
            sram_addr_d = lo_addr_d;
            if (is_write_d) begin
                dq_out_d = wdata_q_d[15:0];
                oe_d     = 1'b1;
                // Release we_n in the last LO cycle so the address change to the
                // high half happens with the write strobe inactive.
                we_n_d   = (WAIT_CYCLES > 1) && (count_d == LAST);
            end
        end else if (state_d == S_HI) begin
            sram_addr_d = lo_addr_d | SRAM_AW'(1);
            if (is_write_d) begin
                dq_out_d = wdata_q_d[31:16];
                oe_d     = 1'b1;
                we_n_d   = 1'b0;
            end
        end
    end

    // State and transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            is_write <= 1'b0;
            lo_addr  <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            is_write <= is_write_d;
            lo_addr  <= lo_addr_d;
            wdata_q  <= wdata_q_d;
        end
    end

    // Registered SRAM pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            sram_addr   <= sram_addr_d;
            sram_dq_out <= dq_out_d;
            sram_dq_oe  <= oe_d;
            sram_we_n   <= we_n_d;
        end
    end

    // Read data is captured from the bus at the last cycle of each read phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (last_c && !is_write) begin
            if (state == S_LO) begin
                rdata[15:0] <= sram_dq_in;
            end else if (state == S_HI) begin
                rdata[31:16] <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_stall_controller.sv
`timescale 1ns/1ps
module tb_mem_stall_controller;
    localparam int unsigned W    = 5;
    localparam int unsigned BASE = 1024;
    localparam int unsigned AW   = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [31:0]   address = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;

    mem_stall_controller #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE),
        .SRAM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Unwritten SRAM locations read back a fixed address-dependent pattern.
    function automatic logic [15:0] pattern(input logic [5:0] i);
        return 16'h5A00 | 16'(i);
    endfunction

    // SRAM model: 64 halfwords, written on every clock while we_n is low.
    logic [15:0] sram [64];
    logic [63:0] sram_mark = '0;
    logic [5:0]  sidx;
    assign sidx       = sram_addr[5:0];
    assign sram_dq_in = sram_mark[sidx] ? sram[sidx] : pattern(sidx);
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram[sidx]      <= sram_dq_out;
            sram_mark[sidx] <= 1'b1;
        end
    end

    // Reference memory and scoreboard.
    typedef struct {
        logic [31:0]   rdata;
        logic [AW-1:0] lo;
        logic          is_wr;
        logic [31:0]   data;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] ref_mem [64];
    logic [63:0] ref_mark;
    logic [31:0] last_rd;

    int vectors = 0;
    int miscompares = 0;
    int unsigned start_cyc;
    int unsigned done_cyc;

    function automatic logic [15:0] ref_rd(input logic [5:0] i);
        return ref_mark[i] ? ref_mem[i] : pattern(i);
    endfunction

    // Drives one request, lets it drop after acceptance, follows the phases and
    // compares pins per cycle, then pops the expected result at DONE.
    task automatic run_access(input logic wr, input logic rd,
                              input logic [31:0] addr, input logic [31:0] data);
        exp_t          e;
        exp_t          cur;
        logic [AW-1:0] lo;
        logic [31:0]   off;
        logic [AW-1:0] exp_addr;
        logic          exp_we_n;
        logic [15:0]   exp_dq;
        bit            done;
        int            k;
        off = addr - BASE;
        lo  = AW'((off >> 2) << 1);
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = addr; wdata = data;
        start_cyc = cyc;
        e.lo = lo; e.is_wr = wr; e.data = data;
        if (wr) begin
            ref_mem[lo[5:0]] = data[15:0];         ref_mark[lo[5:0]] = 1'b1;
            ref_mem[lo[5:0] | 6'd1] = data[31:16]; ref_mark[lo[5:0] | 6'd1] = 1'b1;
        end else begin
            last_rd = {ref_rd(lo[5:0] | 6'd1), ref_rd(lo[5:0])};
        end
        e.rdata = last_rd;
        exp_q.push_back(e);
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_ready: got %b expected 0", ready);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; address = $urandom; wdata = $urandom;
        cur  = exp_q[0];
        done = 0;
        k    = 0;
        while (!done && k < int'(2 * W + 4)) begin
            k++;
            @(negedge clk);
            if (ready === 1'b1) begin
                done = 1;
                done_cyc = cyc;
                e = exp_q.pop_front();
                vectors++;
                if (k != int'(2 * W + 1)) begin
                    miscompares++;
                    $display("FAIL latency: got %0d expected %0d", k, 2 * W + 1);
                end
                vectors++;
                if (rdata !== e.rdata) begin
                    miscompares++;
                    $display("FAIL done_rdata: got %h expected %h", rdata, e.rdata);
                end
                vectors++;
                if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_pins: got we_n=%b oe=%b expected we_n=1 oe=0",
                             sram_we_n, sram_dq_oe);
                end
            end else if (k <= int'(2 * W)) begin
                exp_addr = (k <= int'(W)) ? cur.lo : (cur.lo | AW'(1));
                exp_dq   = (k <= int'(W)) ? cur.data[15:0] : cur.data[31:16];
                exp_we_n = cur.is_wr ? ((k == int'(W)) && (W > 1)) : 1'b1;
                vectors++;
                if (sram_addr !== exp_addr || sram_we_n !== exp_we_n ||
                    sram_dq_oe !== cur.is_wr || (cur.is_wr && sram_dq_out !== exp_dq)) begin
                    miscompares++;
                    $display("FAIL phase_pins k=%0d: got addr=%0d we_n=%b oe=%b dq=%h expected addr=%0d we_n=%b oe=%b dq=%h",
                             k, sram_addr, sram_we_n, sram_dq_oe, sram_dq_out,
                             exp_addr, exp_we_n, cur.is_wr, exp_dq);
                end
            end
        end
        if (!done) begin
            miscompares++;
            vectors++;
            $display("FAIL ready_timeout: got no ready in %0d cycles expected %0d", k, 2 * W + 1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset();
        ref_mark = '0;
        last_rd  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
            rdata !== 32'h0 || sram_addr !== '0 || sram_dq_out !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_values: got ready=%b we_n=%b oe=%b rdata=%h addr=%0d dq=%h expected 1 1 0 0 0 0",
                     ready, sram_we_n, sram_dq_oe, rdata, sram_addr, sram_dq_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
                miscompares++;
                $display("FAIL idle: got ready=%b we_n=%b oe=%b expected 1 1 0",
                         ready, sram_we_n, sram_dq_oe);
            end
        end
    endtask

    task automatic test_write();
        run_access(1'b1, 1'b0, 32'd1024, 32'h0000_2000);
        vectors++;
        if (sram[0] !== 16'h2000 || sram[1] !== 16'h0000) begin
            miscompares++;
            $display("FAIL write_sram: got %h %h expected 2000 0000", sram[0], sram[1]);
        end
    endtask

    task automatic test_read();
        run_access(1'b0, 1'b1, 32'd1024, 32'h0);
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (rdata !== 32'h0000_2000) begin
                miscompares++;
                $display("FAIL rdata_hold: got %h expected 00002000", rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned first_start;
        run_access(1'b0, 1'b1, 32'd1028, 32'h0);
        first_start = start_cyc;
        run_access(1'b0, 1'b1, 32'd1032, 32'h0);
        vectors++;
        if (done_cyc - first_start != 2 * (2 * W + 1) + 1) begin
            miscompares++;
            $display("FAIL b2b_ready_cycle: got %0d expected %0d",
                     done_cyc - first_start, 2 * (2 * W + 1) + 1);
        end
        vectors++;
        if (rdata !== 32'h5A05_5A04) begin
            miscompares++;
            $display("FAIL b2b_rdata: got %h expected 5a055a04", rdata);
        end
    endtask

    task automatic test_rd_wr_both();
        run_access(1'b1, 1'b1, 32'd1036, 32'hDEAD_BEEF);
        vectors++;
        if (sram[6] !== 16'hBEEF || sram[7] !== 16'hDEAD) begin
            miscompares++;
            $display("FAIL both_write_sram: got %h %h expected beef dead", sram[6], sram[7]);
        end
        run_access(1'b0, 1'b1, 32'd1036, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; wdata = 32'h1111_2222;
        @(posedge clk); #1;
        wr_en = 1'b0; address = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: got ready=%b we_n=%b oe=%b expected 1 1 0",
                     ready, sram_we_n, sram_dq_oe);
        end
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        #1;
        vectors++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || rdata !== 32'h0 || sram_mark[9] !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abort: got ready=%b we_n=%b rdata=%h hi_written=%b expected 1 1 0 0",
                     ready, sram_we_n, rdata, sram_mark[9]);
        end
        run_access(1'b1, 1'b0, 32'd1044, 32'hCAFE_F00D);
        vectors++;
        if (sram[10] !== 16'hF00D || sram[11] !== 16'hCAFE) begin
            miscompares++;
            $display("FAIL post_rst_write: got %h %h expected f00d cafe", sram[10], sram[11]);
        end
        run_access(1'b0, 1'b1, 32'd1044, 32'h0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write();
        test_read();
        test_back_to_back();
        test_rd_wr_both();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
